// File: rtl/noc_packetizer.sv
// noc_packetizer: wraps one user word and a destination into a 4-slot
// multi-flit packet word behind a single-entry registered output stage.
module noc_packetizer #(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_IN         = 400,
   parameter int WIDTH_OUT        = 512,
   parameter int ASSIGNED_VC      = 0
) (
   input  logic                     clk_rtl,
   input  logic                     rst,
   input  logic [WIDTH_IN-1:0]      i_data_in,
   input  logic                     i_valid_in,
   input  logic [ADDRESS_WIDTH-1:0] i_dest_in,
   output logic                     i_ready_out,
   output logic [WIDTH_OUT-1:0]     o_data_out,
   output logic                     o_valid_out,
   input  logic                     o_ready_in
);

   localparam int WF      = WIDTH_OUT / 4;
   localparam int HDR     = 3 + ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
   localparam int FD      = WF - HDR;
   localparam int FD_SAFE = (FD < 1) ? 1 : FD;
   localparam int NF      = (WIDTH_IN + FD_SAFE - 1) / FD_SAFE;

   localparam logic [VC_ADDRESS_WIDTH-1:0] VC_ID =
      VC_ADDRESS_WIDTH'(ASSIGNED_VC);

   if (NF > 4 || FD < 1 || (WIDTH_OUT % 4) != 0) begin : g_bad_cfg
      $error("noc_packetizer: payload does not fit in 4 flits");
   end

   logic [4*FD_SAFE-1:0]  data_pad;
   logic [WIDTH_OUT-1:0]  packet;
   logic                  accept;
   logic                  valid_q;
   logic [WIDTH_OUT-1:0]  data_q;

   // Zero-extend the user word so the last flit carries zeros past WIDTH_IN
   always_comb begin
      data_pad = '0;
      data_pad[WIDTH_IN-1:0] = i_data_in;
   end

   // Build all flit slots; unused trailing slots stay all-zero
   always_comb begin
      packet = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < NF) begin
            packet[WIDTH_OUT-1-k*WF -: WF] = {
               1'b1,
               (k == 0),
               (k == NF - 1),
               i_dest_in,
               VC_ID,
               data_pad[k*FD_SAFE +: FD_SAFE]
            };
         end
      end
   end

   // Single-entry pipe: free when empty or draining this cycle
   always_comb begin
      i_ready_out = !valid_q || o_ready_in;
      accept      = i_valid_in && i_ready_out;
   end

   // Output register; a drain and a new accept on one edge just replace
   always_ff @(posedge clk_rtl or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         data_q  <= packet;
      end else if (o_ready_in) begin
         valid_q <= 1'b0;
      end
   end

   assign o_valid_out = valid_q;
   assign o_data_out  = data_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: directed checks of flit formatting, handshake,
// backpressure and reset for several payload widths.
`timescale 1ns/1ps
module tb_noc_packetizer;

   int checks = 0;
   int errors = 0;

   logic clk_rtl = 1'b0;
   logic rst;

   always #5 clk_rtl = ~clk_rtl;

   // Default-width DUT
   logic [399:0] d0;
   logic         v0;
   logic [3:0]   dest0;
   logic         rdy0;
   logic [511:0] q0;
   logic         ov0;
   logic         ordy0;

   // Narrow DUTs share one handshake stimulus set
   logic [15:0]  d1;
   logic [159:0] d2;
   logic [259:0] d3;
   logic         v1;
   logic [3:0]   dest1;
   logic         ordy1;
   logic         rdy1, rdy2, rdy3;
   logic [511:0] q1, q2, q3;
   logic         ov1, ov2, ov3;

   noc_packetizer u0 (
      .clk_rtl(clk_rtl), .rst(rst),
      .i_data_in(d0), .i_valid_in(v0), .i_dest_in(dest0),
      .i_ready_out(rdy0), .o_data_out(q0),
      .o_valid_out(ov0), .o_ready_in(ordy0)
   );

   noc_packetizer #(.WIDTH_IN(16)) u1 (
      .clk_rtl(clk_rtl), .rst(rst),
      .i_data_in(d1), .i_valid_in(v1), .i_dest_in(dest1),
      .i_ready_out(rdy1), .o_data_out(q1),
      .o_valid_out(ov1), .o_ready_in(ordy1)
   );

   noc_packetizer #(.WIDTH_IN(160)) u2 (
      .clk_rtl(clk_rtl), .rst(rst),
      .i_data_in(d2), .i_valid_in(v1), .i_dest_in(dest1),
      .i_ready_out(rdy2), .o_data_out(q2),
      .o_valid_out(ov2), .o_ready_in(ordy1)
   );

   noc_packetizer #(.WIDTH_IN(260)) u3 (
      .clk_rtl(clk_rtl), .rst(rst),
      .i_data_in(d3), .i_valid_in(v1), .i_dest_in(dest1),
      .i_ready_out(rdy3), .o_data_out(q3),
      .o_valid_out(ov3), .o_ready_in(ordy1)
   );

   function automatic logic [479:0] reasm(input logic [511:0] p);
      logic [479:0] r;
      for (int k = 0; k < 4; k++)
         r[k*120 +: 120] = p[503-k*128 -: 120];
      return r;
   endfunction

   function automatic logic [7:0] hdr(input logic [511:0] p,
                                      input int k);
      return p[511-k*128 -: 8];
   endfunction

   function automatic logic [399:0] rand400();
      logic [415:0] t;
      for (int j = 0; j < 13; j++)
         t[j*32 +: 32] = $urandom;
      return t[399:0];
   endfunction

   task automatic test_reset();
      @(negedge clk_rtl);
      d0 = 400'h1234; dest0 = 4'd2; v0 = 1'b1; ordy0 = 1'b0;
      @(negedge clk_rtl);
      v0 = 1'b0;
      checks++;
      if (ov0 !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_valid: got %b exp 1", ov0);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (ov0 !== 1'b0) begin
         errors++;
         $display("FAIL rst_async_valid: got %b exp 0", ov0);
      end
      checks++;
      if (q0 !== 512'h0) begin
         errors++;
         $display("FAIL rst_async_data: got %h exp 0", q0);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (rdy0 !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready: got %b exp 1", rdy0);
      end
   endtask

   task automatic test_format_default();
      @(negedge clk_rtl);
      d0 = '0;
      d0[31:0]    = 32'hBAADF00D;
      d0[239:120] = 120'h123456789ABCDEF0123456789ABCDE;
      d0[399:360] = 40'hCAFEBABE12;
      dest0 = 4'd1; v0 = 1'b1; ordy0 = 1'b1;
      @(negedge clk_rtl);
      v0 = 1'b0;
      checks++;
      if (ov0 !== 1'b1) begin
         errors++;
         $display("FAIL fmt_valid: got %b exp 1", ov0);
      end
      checks++;
      if (q0[511:504] !== 8'hC2) begin
         errors++;
         $display("FAIL fmt_hdr0: got %h exp c2", q0[511:504]);
      end
      checks++;
      if (q0[383:376] !== 8'h82 || q0[255:248] !== 8'h82) begin
         errors++;
         $display("FAIL fmt_hdr12: got %h %h exp 82 82",
                  q0[383:376], q0[255:248]);
      end
      checks++;
      if (q0[127:120] !== 8'hA2) begin
         errors++;
         $display("FAIL fmt_hdr3: got %h exp a2", q0[127:120]);
      end
      checks++;
      if (q0[503:384] !== 120'hBAADF00D) begin
         errors++;
         $display("FAIL fmt_data0: got %h exp baadf00d", q0[503:384]);
      end
      checks++;
      if (q0[375:256] !== 120'h123456789ABCDEF0123456789ABCDE) begin
         errors++;
         $display("FAIL fmt_data1: got %h", q0[375:256]);
      end
      checks++;
      if (q0[247:128] !== 120'h0) begin
         errors++;
         $display("FAIL fmt_data2: got %h exp 0", q0[247:128]);
      end
      checks++;
      if (q0[119:0] !== 120'hCAFEBABE12) begin
         errors++;
         $display("FAIL fmt_data3: got %h exp cafebabe12", q0[119:0]);
      end
      @(negedge clk_rtl);
      checks++;
      if (ov0 !== 1'b0) begin
         errors++;
         $display("FAIL fmt_drain: got %b exp 0", ov0);
      end
   endtask

   task automatic test_narrow_widths();
      @(negedge clk_rtl);
      d1 = 16'hBEEF;
      d2 = {40'hA5A5A5A5A5, 120'h0F0E0D0C0B0A09080706050403020};
      d3 = {20'hFEDCB, 120'h1, 120'h2};
      dest1 = 4'd5; v1 = 1'b1; ordy1 = 1'b1;
      @(negedge clk_rtl);
      v1 = 1'b0;
      checks++;
      if (ov1 !== 1'b1 || q1[511:504] !== 8'hEA) begin
         errors++;
         $display("FAIL w16_hdr: got %b %h exp 1 ea", ov1, q1[511:504]);
      end
      checks++;
      if (q1[503:384] !== 120'hBEEF || q1[383:0] !== 384'h0) begin
         errors++;
         $display("FAIL w16_body: got %h exp beef then zero", q1);
      end
      checks++;
      if (q2[511:504] !== 8'hCA || q2[383:376] !== 8'hAA) begin
         errors++;
         $display("FAIL w160_hdr: got %h %h exp ca aa",
                  q2[511:504], q2[383:376]);
      end
      checks++;
      if (q2[503:384] !== 120'h0F0E0D0C0B0A09080706050403020 ||
          q2[375:256] !== 120'hA5A5A5A5A5 || q2[255:0] !== 256'h0) begin
         errors++;
         $display("FAIL w160_body: got %h", q2);
      end
      checks++;
      if (q3[511:504] !== 8'hCA || q3[383:376] !== 8'h8A ||
          q3[255:248] !== 8'hAA) begin
         errors++;
         $display("FAIL w260_hdr: got %h %h %h exp ca 8a aa",
                  q3[511:504], q3[383:376], q3[255:248]);
      end
      checks++;
      if (q3[503:384] !== 120'h2 || q3[375:256] !== 120'h1 ||
          q3[247:128] !== 120'hFEDCB || q3[127:0] !== 128'h0) begin
         errors++;
         $display("FAIL w260_body: got %h", q3);
      end
   endtask

   task automatic test_backpressure();
      logic [399:0] w1, w2;
      w1 = rand400();
      w2 = rand400();
      @(negedge clk_rtl);
      d0 = w1; dest0 = 4'd3; v0 = 1'b1; ordy0 = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_rtl);
         d0 = rand400(); dest0 = 4'(c + 7);
         #1;
         checks++;
         if (rdy0 !== 1'b0 || ov0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall c%0d: rdy %b vld %b exp 0 1",
                     c, rdy0, ov0);
         end
         checks++;
         if (reasm(q0) !== {80'h0, w1} || hdr(q0, 0) !== 8'hC6) begin
            errors++;
            $display("FAIL bp_hold c%0d: got %h", c, q0);
         end
      end
      @(negedge clk_rtl);
      d0 = w2; dest0 = 4'd3; ordy0 = 1'b1;
      #1;
      checks++;
      if (rdy0 !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: got %b exp 1", rdy0);
      end
      @(negedge clk_rtl);
      v0 = 1'b0;
      checks++;
      if (ov0 !== 1'b1 || reasm(q0) !== {80'h0, w2}) begin
         errors++;
         $display("FAIL bp_next: vld %b data %h", ov0, q0);
      end
      @(negedge clk_rtl);
      checks++;
      if (ov0 !== 1'b0) begin
         errors++;
         $display("FAIL bp_nodup: got %b exp 0", ov0);
      end
   endtask

   task automatic test_stream();
      logic [399:0] w [100];
      logic [3:0]   dd [100];
      logic [7:0]   eh;
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
         w[i]  = rand400();
         dd[i] = 4'($urandom);
      end
      ordy0 = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk_rtl);
         if (i > 0) begin
            checks++;
            if (ov0 !== 1'b1 || reasm(q0) !== {80'h0, w[i-1]}) begin
               errors++;
               if (bad++ < 5)
                  $display("FAIL stream_data %0d: vld %b got %h",
                           i - 1, ov0, q0);
            end
            for (int k = 0; k < 4; k++) begin
               eh = {1'b1, (k == 0), (k == 3), dd[i-1], 1'b0};
               checks++;
               if (hdr(q0, k) !== eh) begin
                  errors++;
                  if (bad++ < 5)
                     $display("FAIL stream_hdr %0d.%0d: got %h exp %h",
                              i - 1, k, hdr(q0, k), eh);
               end
            end
         end
         if (i < 100) begin
            d0 = w[i]; dest0 = dd[i]; v0 = 1'b1;
            #1;
            checks++;
            if (rdy0 !== 1'b1) begin
               errors++;
               $display("FAIL stream_ready %0d: got %b exp 1", i, rdy0);
            end
         end else begin
            v0 = 1'b0;
         end
      end
   endtask

   task automatic test_random_ready();
      logic [399:0] qd [$];
      logic [3:0]   qa [$];
      logic [399:0] ew;
      logic [3:0]   ea;
      int sent = 0;
      int got  = 0;
      int bad  = 0;
      int cyc  = 0;
      while ((sent < 1000 || qd.size() != 0) && cyc < 20000) begin
         @(negedge clk_rtl);
         cyc++;
         ordy0 = ($urandom_range(0, 3) != 0);
         if (sent < 1000 && $urandom_range(0, 4) != 0) begin
            d0 = rand400(); dest0 = 4'($urandom); v0 = 1'b1;
         end else begin
            v0 = 1'b0;
         end
         #1;
         if (ov0 && !ordy0) begin
            checks++;
            if (rdy0 !== 1'b0) begin
               errors++;
               $display("FAIL rr_ready_stall: got %b exp 0", rdy0);
            end
         end
         if (ov0 && ordy0) begin
            checks++;
            if (qd.size() == 0) begin
               errors++;
               $display("FAIL rr_extra: got %h exp none", q0);
            end else begin
               ew = qd.pop_front();
               ea = qa.pop_front();
               if (reasm(q0) !== {80'h0, ew} ||
                   hdr(q0, 0) !== {3'b110, ea, 1'b0} ||
                   hdr(q0, 3) !== {3'b101, ea, 1'b0}) begin
                  errors++;
                  if (bad++ < 5)
                     $display("FAIL rr_word %0d: got %h exp %h", got,
                              q0, ew);
               end
               got++;
            end
         end
         if (v0 && rdy0) begin
            qd.push_back(d0);
            qa.push_back(dest0);
            sent++;
         end
      end
      @(negedge clk_rtl);
      v0 = 1'b0;
      checks++;
      if (got != 1000 || sent != 1000) begin
         errors++;
         $display("FAIL rr_count: got %0d sent %0d exp 1000", got, sent);
      end
   endtask

   initial begin
      rst = 1'b1;
      d0 = '0; v0 = 1'b0; dest0 = '0; ordy0 = 1'b0;
      d1 = '0; d2 = '0; d3 = '0;
      v1 = 1'b0; dest1 = '0; ordy1 = 1'b0;
      #3;
      checks++;
      if (ov0 !== 1'b0 || q0 !== 512'h0 || ov1 !== 1'b0) begin
         errors++;
         $display("FAIL por_state: vld %b data %h", ov0, q0);
      end
      @(negedge clk_rtl);
      rst = 1'b0;
      #1;
      checks++;
      if (rdy0 !== 1'b1 || rdy2 !== 1'b1) begin
         errors++;
         $display("FAIL por_ready: got %b %b exp 1 1", rdy0, rdy2);
      end
      test_reset();
      test_format_default();
      test_narrow_widths();
      test_backpressure();
      test_stream();
      test_random_ready();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Converts one wide user data word plus destination router address into a multi-flit NoC packet word on the RTL side of the fabric interface.
- Accepts the word on a ready/valid interface and presents the packet on a registered ready/valid interface that feeds a fabric-interface input port.
- Packet words are WIDTH_OUT wide, made of 4 flit slots.

Parameters:
ADDRESS_WIDTH, 4, width of destination router address (log2 of node count).
VC_ADDRESS_WIDTH, 1, width of virtual-channel id field.
WIDTH_IN, 400, user data width.
WIDTH_OUT, 512, packet word width; must be divisible by 4.
ASSIGNED_VC, 0, VC id written into every flit.

Ports:
clk_rtl  input  1  module clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
i_data_in  input  WIDTH_IN  user data.
i_valid_in  input  1  user data valid.
i_dest_in  input  ADDRESS_WIDTH  destination node.
i_ready_out  output  1  block can accept this cycle.
o_data_out  output  WIDTH_OUT  formatted packet.
o_valid_out  output  1  packet valid.
o_ready_in  input  1  downstream (fabric interface) ready.

Behaviour:
- Derived values:
  - WF = WIDTH_OUT/4 (flit width, 128 by default).
  - HDR = 3 + ADDRESS_WIDTH + VC_ADDRESS_WIDTH.
  - FD = WF − HDR (data bits per flit, 120 by default).
  - NF = ceil(WIDTH_IN/FD).
- Elaboration error if NF > 4 or FD < 1.
- Flit layout, MSB first: valid(1), head(1), tail(1), dest(ADDRESS_WIDTH), vc(VC_ADDRESS_WIDTH), data(FD).
- Flit k (k=0..3) occupies o_data_out[WIDTH_OUT−1−k·WF −: WF]; flit 0 is in the MSBs.
- For k < NF:
  - valid = 1.
  - head = (k == 0).
  - tail = (k == NF−1).
  - dest = i_dest_in.
  - vc = ASSIGNED_VC.
  - data = i_data_in[k·FD +: FD]; bits beyond WIDTH_IN are zero.
- Single-flit packet: head = tail = 1.
- Flit slots k ≥ NF are all zero.
- Handshake:
  - Accept when i_valid_in && i_ready_out.
  - i_ready_out = !o_valid_out || o_ready_in (combinational; a 1-entry pipeline register).
  - On accept, the formatted packet is registered and o_valid_out = 1 on the next cycle. Latency is 1 cycle.
  - Sustained throughput is 1 packet/cycle while o_ready_in = 1.
- Stall: while o_valid_out && !o_ready_in, o_data_out and o_valid_out hold exactly stable, and i_ready_out = 0.
- If the output register drains (o_ready_in = 1) with no new accept, o_valid_out goes to 0 next cycle. o_data_out may hold its stale value.
- Simultaneous drain and accept: the new packet replaces the old one in the same edge, with no bubble.
- i_dest_in and i_data_in are sampled only on accept; changes at other times have no effect.
- Reset (asynchronous, any time including mid-stall): o_valid_out = 0 and o_data_out = 0 immediately. Any held packet is discarded.
- After reset release, i_ready_out = 1.

Test Plan:
- Reset: assert rst mid-stall with a packet held -> o_valid_out = 0 and o_data_out = 0 immediately; i_ready_out = 1 after release.
- Defaults, 400-bit data = 0x…BAADF00D, dest = 1, o_ready_in = 1, accept -> next cycle, 4 flits each with valid = 1, dest = 1, vc = 0:
  - flit0: head = 1, tail = 0.
  - flit3: head = 0, tail = 1.
  - flit0 data = i_data_in[119:0]; flit3 data = {80'b0, i_data_in[399:360]}.
- WIDTH_IN = 16, dest = 5 -> flit0 has head = tail = 1 and data zero-extended; flits 1..3 are all zero. WIDTH_IN = 160 -> 2 valid flits. WIDTH_IN = 260 -> 3 valid flits.
- Backpressure: hold o_ready_in = 0 for 5 cycles with i_valid_in = 1 -> one packet captured, i_ready_out = 0, outputs stable. Release o_ready_in -> the next word is accepted the same cycle, and there is no loss or duplication.
- Streaming: 100 random words with o_ready_in = 1 -> 100 packets in order, one per cycle, each field-exact to its source word.
- Random o_ready_in toggling over 1000 words -> the scoreboard (reassembling data from flits) matches every word, with no drops.
